// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, two-cycle EX redirects and
// data-memory freezes. Define HAZARD_PERF_EN to build the stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        mem_req,
  input  logic        dmem_ready,
  input  logic        imem_ready,
  output logic        stall,
  output logic        flush,
  output logic [31:0] branch_PC,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_bubble,
  output logic        exmem_stall,
  output logic        memwb_bubble,
  output logic        redirect_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  typedef enum logic [1:0] {StRun, StRedirect, StMemWait} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [31:0] r_target;
  logic [31:0] w_target_d;
  logic        r_redirect_err;

  logic        w_lu;
  logic        w_freeze;
  logic        w_eval;
  logic        w_err_set;
  logic        w_lu_take;
  logic        w_stall;
  logic        w_flush;
  logic [31:0] w_branch_pc;
  logic        w_ifid_stall;
  logic        w_ifid_flush;
  logic        w_idex_stall;
  logic        w_idex_bubble;
  logic        w_exmem_stall;
  logic        w_memwb_bubble;

  // RESET_PC is documentation only; the redirect target register always resets to 0.
  logic w_unused_reset_pc;
  assign w_unused_reset_pc = ^RESET_PC;

  assign w_lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign w_freeze = mem_req && !dmem_ready;

  // Cases that follow the memory freeze in RUN, also used when MEM_WAIT releases.
  assign w_eval = ((r_state == StRun) && !w_freeze) || ((r_state == StMemWait) && dmem_ready);

  always_comb begin
    w_state_d      = r_state;
    w_target_d     = r_target;
    w_err_set      = 1'b0;
    w_lu_take      = 1'b0;
    w_stall        = 1'b0;
    w_flush        = 1'b0;
    w_branch_pc    = 32'd0;
    w_ifid_stall   = 1'b0;
    w_ifid_flush   = 1'b0;
    w_idex_stall   = 1'b0;
    w_idex_bubble  = 1'b0;
    w_exmem_stall  = 1'b0;
    w_memwb_bubble = 1'b0;

    unique case (r_state)
      StRun: begin
        if (w_freeze) begin
          w_state_d = StMemWait;
        end
      end
      StRedirect: begin
        if (!w_freeze) begin
          w_branch_pc   = r_target;
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
          w_state_d     = StRun;
        end
      end
      StMemWait: begin
        if (dmem_ready) begin
          w_state_d = StRun;
        end
      end
      default: w_state_d = StRun;
    endcase

    if ((r_state != StMemWait && w_freeze) || (r_state == StMemWait && !dmem_ready)) begin
      w_stall        = 1'b1;
      w_ifid_stall   = 1'b1;
      w_idex_stall   = 1'b1;
      w_exmem_stall  = 1'b1;
      w_memwb_bubble = 1'b1;
    end

    if (w_eval) begin
      if (ex_redirect && (ex_target != 32'd0)) begin
        w_ifid_flush  = 1'b1;
        w_idex_bubble = 1'b1;
        w_target_d    = ex_target;
        w_state_d     = StRedirect;
      end else if (ex_redirect) begin
        // Zero target: flush the wrong path but keep the old target and flag the error.
        w_ifid_flush  = 1'b1;
        w_idex_bubble = 1'b1;
        w_err_set     = 1'b1;
        w_state_d     = StRun;
      end else if (w_lu) begin
        w_stall       = 1'b1;
        w_ifid_stall  = 1'b1;
        w_idex_bubble = 1'b1;
        w_lu_take     = 1'b1;
      end else if (!imem_ready) begin
        w_flush      = 1'b1;
        w_ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= StRun;
      r_target       <= 32'd0;
      r_redirect_err <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_target <= w_target_d;
      if (w_err_set) begin
        r_redirect_err <= 1'b1;
      end
    end
  end

  assign stall        = reset & w_stall;
  assign flush        = reset & w_flush;
  assign branch_PC    = reset ? w_branch_pc : 32'd0;
  assign ifid_stall   = reset & w_ifid_stall;
  assign ifid_flush   = reset & w_ifid_flush;
  assign idex_stall   = reset & w_idex_stall;
  assign idex_bubble  = reset & w_idex_bubble;
  assign exmem_stall  = reset & w_exmem_stall;
  assign memwb_bubble = reset & w_memwb_bubble;
  assign redirect_err = reset & r_redirect_err;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;
  logic        w_redirect_entry;

  assign w_redirect_entry = (w_state_d == StRedirect) && (r_state != StRedirect);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cycles <= 32'd0;
      r_flush_events <= 32'd0;
    end else begin
      if (w_stall) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_redirect_entry || w_lu_take) begin
        r_flush_events <= r_flush_events + 32'd1;
      end
    end
  end

  assign stall_cycles = reset ? r_stall_cycles : 32'd0;
  assign flush_events = reset ? r_flush_events : 32'd0;
`else
  logic w_unused_lu_take;
  assign w_unused_lu_take = w_lu_take;
  assign stall_cycles     = 32'd0;
  assign flush_events     = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; counter checks follow HAZARD_PERF_EN.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic [31:0] ex_target;
  logic        mem_req, dmem_ready, imem_ready;
  logic        stall, flush, ifid_stall, ifid_flush, idex_stall, idex_bubble;
  logic        exmem_stall, memwb_bubble, redirect_err;
  logic [31:0] branch_PC, stall_cycles, flush_events;

  int total = 0;
  int bad   = 0;

  // {stall, flush, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, memwb_bubble,
  //  redirect_err}
  logic [8:0] ctl;
  assign ctl = {stall, flush, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall,
                memwb_bubble, redirect_err};

  localparam logic [8:0] CtlIdle   = 9'b000000000;
  localparam logic [8:0] CtlFreeze = 9'b101010110;
  localparam logic [8:0] CtlLu     = 9'b101001000;
  localparam logic [8:0] CtlRedir  = 9'b000101000;
  localparam logic [8:0] CtlImem   = 9'b010100000;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .mem_req      (mem_req),
    .dmem_ready   (dmem_ready),
    .imem_ready   (imem_ready),
    .stall        (stall),
    .flush        (flush),
    .branch_PC    (branch_PC),
    .ifid_stall   (ifid_stall),
    .ifid_flush   (ifid_flush),
    .idex_stall   (idex_stall),
    .idex_bubble  (idex_bubble),
    .exmem_stall  (exmem_stall),
    .memwb_bubble (memwb_bubble),
    .redirect_err (redirect_err),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  task automatic idle();
    reset       = 1'b1;
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0;
    ex_rd       = 5'd0;
    ex_redirect = 1'b0;
    ex_target   = 32'd0;
    mem_req     = 1'b0;
    dmem_ready  = 1'b1;
    imem_ready  = 1'b1;
  endtask

  // Inputs are driven just after a rising edge; outputs are sampled on the falling edge.
  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset       = 1'b0;
    mem_req     = 1'b1;
    dmem_ready  = 1'b0;
    ex_redirect = 1'b1;
    ex_target   = 32'h00400040;
    imem_ready  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      to_sample();
      total++;
      if (ctl !== CtlIdle) begin
        bad++;
        $display("FAIL reset_ctl[%0d] got=%b want=%b", i, ctl, CtlIdle);
      end
      total++;
      if (branch_PC !== 32'd0) begin
        bad++;
        $display("FAIL reset_branch_pc[%0d] got=%h want=0", i, branch_PC);
      end
      next_cycle();
    end
    idle();
    to_sample();
    total++;
    if (ctl !== CtlIdle || branch_PC !== 32'd0) begin
      bad++;
      $display("FAIL reset_release got=%b/%h want=%b/0", ctl, branch_PC, CtlIdle);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    // {ex_mem_read, ex_rd, rs1, uses1, rs2, uses2, expect stall}
    logic [18:0] vec [6];
    vec[0] = {1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1};
    vec[1] = {1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0};
    vec[2] = {1'b1, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1, 1'b1};
    vec[3] = {1'b1, 5'd7, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0};
    vec[4] = {1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0};
    vec[5] = {1'b1, 5'd3, 5'd4, 1'b1, 5'd2, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      idle();
      {ex_mem_read, ex_rd, id_rs1, id_uses_rs1, id_rs2, id_uses_rs2} = vec[i][18:1];
      to_sample();
      total++;
      if (ctl !== (vec[i][0] ? CtlLu : CtlIdle)) begin
        bad++;
        $display("FAIL load_use[%0d] got=%b want=%b", i, ctl, vec[i][0] ? CtlLu : CtlIdle);
      end
      next_cycle();
      idle();
      to_sample();
      total++;
      if (ctl !== CtlIdle) begin
        bad++;
        $display("FAIL load_use_after[%0d] got=%b want=%b", i, ctl, CtlIdle);
      end
      next_cycle();
    end
  endtask

  task automatic test_imem_wait();
    idle();
    imem_ready = 1'b0;
    to_sample();
    total++;
    if (ctl !== CtlImem) begin
      bad++;
      $display("FAIL imem_wait got=%b want=%b", ctl, CtlImem);
    end
    next_cycle();
    // Load-use outranks a fetch miss.
    ex_mem_read = 1'b1;
    ex_rd       = 5'd12;
    id_rs1      = 5'd12;
    id_uses_rs1 = 1'b1;
    to_sample();
    total++;
    if (ctl !== CtlLu) begin
      bad++;
      $display("FAIL imem_vs_lu got=%b want=%b", ctl, CtlLu);
    end
    next_cycle();
  endtask

  task automatic test_redirect();
    idle();
    ex_redirect = 1'b1;
    ex_target   = 32'h00400040;
    to_sample();
    total++;
    if (ctl !== CtlRedir || branch_PC !== 32'd0) begin
      bad++;
      $display("FAIL redirect_n got=%b/%h want=%b/0", ctl, branch_PC, CtlRedir);
    end
    next_cycle();
    idle();
    to_sample();
    total++;
    if (ctl !== CtlRedir || branch_PC !== 32'h00400040) begin
      bad++;
      $display("FAIL redirect_n1 got=%b/%h want=%b/00400040", ctl, branch_PC, CtlRedir);
    end
    next_cycle();
    to_sample();
    total++;
    if (ctl !== CtlIdle || branch_PC !== 32'd0) begin
      bad++;
      $display("FAIL redirect_n2 got=%b/%h want=%b/0", ctl, branch_PC, CtlIdle);
    end
    next_cycle();
  endtask

  task automatic test_redirect_freeze();
    idle();
    ex_redirect = 1'b1;
    ex_target   = 32'h00400080;
    next_cycle();
    idle();
    mem_req    = 1'b1;
    dmem_ready = 1'b0;
    to_sample();
    total++;
    if (ctl !== CtlFreeze || branch_PC !== 32'd0) begin
      bad++;
      $display("FAIL redir_freeze got=%b/%h want=%b/0", ctl, branch_PC, CtlFreeze);
    end
    next_cycle();
    dmem_ready = 1'b1;
    to_sample();
    total++;
    if (ctl !== CtlRedir || branch_PC !== 32'h00400080) begin
      bad++;
      $display("FAIL redir_release got=%b/%h want=%b/00400080", ctl, branch_PC, CtlRedir);
    end
    next_cycle();
    idle();
    to_sample();
    total++;
    if (ctl !== CtlIdle || branch_PC !== 32'd0) begin
      bad++;
      $display("FAIL redir_freeze_done got=%b/%h want=%b/0", ctl, branch_PC, CtlIdle);
    end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    idle();
    mem_req     = 1'b1;
    dmem_ready  = 1'b0;
    ex_redirect = 1'b1;
    ex_target   = 32'h00400100;
    for (int i = 0; i < 4; i++) begin
      to_sample();
      total++;
      if (ctl !== CtlFreeze || branch_PC !== 32'd0) begin
        bad++;
        $display("FAIL mem_wait[%0d] got=%b/%h want=%b/0", i, ctl, branch_PC, CtlFreeze);
      end
      next_cycle();
    end
    dmem_ready = 1'b1;
    to_sample();
    total++;
    if (ctl !== CtlRedir || branch_PC !== 32'd0) begin
      bad++;
      $display("FAIL mem_ready got=%b/%h want=%b/0", ctl, branch_PC, CtlRedir);
    end
    next_cycle();
    idle();
    to_sample();
    total++;
    if (ctl !== CtlRedir || branch_PC !== 32'h00400100) begin
      bad++;
      $display("FAIL mem_redirect got=%b/%h want=%b/00400100", ctl, branch_PC, CtlRedir);
    end
    next_cycle();
    to_sample();
    total++;
    if (ctl !== CtlIdle) begin
      bad++;
      $display("FAIL mem_done got=%b want=%b", ctl, CtlIdle);
    end
    next_cycle();
  endtask

  task automatic test_zero_target();
    idle();
    ex_redirect = 1'b1;
    ex_target   = 32'd0;
    to_sample();
    total++;
    if (ctl !== CtlRedir || branch_PC !== 32'd0) begin
      bad++;
      $display("FAIL zero_target_n got=%b/%h want=%b/0", ctl, branch_PC, CtlRedir);
    end
    next_cycle();
    idle();
    for (int i = 0; i < 2; i++) begin
      to_sample();
      total++;
      if (ctl !== 9'b000000001 || branch_PC !== 32'd0) begin
        bad++;
        $display("FAIL zero_target_err[%0d] got=%b/%h want=000000001/0", i, ctl, branch_PC);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_redirect();
    idle();
    ex_redirect = 1'b1;
    ex_target   = 32'h00400200;
    next_cycle();
    idle();
    reset = 1'b0;
    to_sample();
    total++;
    if (ctl !== CtlIdle || branch_PC !== 32'd0) begin
      bad++;
      $display("FAIL rst_redir_n1 got=%b/%h want=%b/0", ctl, branch_PC, CtlIdle);
    end
    next_cycle();
    idle();
    to_sample();
    total++;
    if (ctl !== CtlIdle || branch_PC !== 32'd0) begin
      bad++;
      $display("FAIL rst_redir_n2 got=%b/%h want=%b/0", ctl, branch_PC, CtlIdle);
    end
    total++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      bad++;
      $display("FAIL rst_redir_counters got=%h/%h want=0/0", stall_cycles, flush_events);
    end
    next_cycle();
  endtask

  task automatic test_counters();
    idle();
`ifdef HAZARD_PERF_EN
    dut.r_stall_cycles = 32'hFFFFFFFF;
`endif
    ex_mem_read = 1'b1;
    ex_rd       = 5'd5;
    id_rs1      = 5'd5;
    id_uses_rs1 = 1'b1;
    to_sample();
    total++;
    if (ctl !== CtlLu) begin
      bad++;
      $display("FAIL cnt_stall got=%b want=%b", ctl, CtlLu);
    end
    next_cycle();
    idle();
    to_sample();
`ifdef HAZARD_PERF_EN
    total++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd1) begin
      bad++;
      $display("FAIL cnt_wrap got=%h/%h want=0/1", stall_cycles, flush_events);
    end
`else
    total++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      bad++;
      $display("FAIL cnt_tied got=%h/%h want=0/0", stall_cycles, flush_events);
    end
`endif
    next_cycle();
  endtask

  initial begin
    idle();
    #1;
    test_reset();
    test_load_use();
    test_imem_wait();
    test_redirect();
    test_redirect_freeze();
    test_mem_wait();
    test_zero_target();
    test_reset_redirect();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
